// File: rtl/if_id_register.sv
// if_id_register: IF/ID pipeline register with stall hold and flush bubble insertion.
module if_id_register #(
  parameter int INST_WIDTH = 16,
  parameter int PC_WIDTH = 16,
  parameter logic [INST_WIDTH-1:0] NOP_INST = 16'h0000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [INST_WIDTH-1:0] if_id_inst_in,
  input  logic [PC_WIDTH-1:0]   if_id_pc_in,
  input  logic                  if_id_valid_in,
  input  logic                  if_id_stall,
  input  logic                  if_id_flush,
  output logic [INST_WIDTH-1:0] if_id_out,
  output logic [PC_WIDTH-1:0]   if_id_pc_out,
  output logic                  if_id_valid_out
);
  // Declaration initialisers give the bubble state at power-up, before any reset.
  logic [INST_WIDTH-1:0] inst_q = NOP_INST;
  logic [PC_WIDTH-1:0] pc_q = '0;
  logic valid_q = 1'b0;
  always_ff @(posedge clock) begin
    if (reset || if_id_flush) begin
      inst_q <= NOP_INST;
      pc_q <= '0;
      valid_q <= 1'b0;
    end else if (!if_id_stall) begin
      inst_q <= if_id_inst_in;
      pc_q <= if_id_pc_in;
      valid_q <= if_id_valid_in;
    end
  end
  assign if_id_out = inst_q;
  assign if_id_pc_out = pc_q;
  assign if_id_valid_out = valid_q;
endmodule

// File: tb/tb_if_id_register.sv
// tb_if_id_register: table-driven check of load, stall, flush and reset behaviour.
module tb_if_id_register;
  logic clock = 1'b0;
  logic reset, if_id_valid_in, if_id_stall, if_id_flush;
  logic [15:0] if_id_inst_in, if_id_pc_in;
  logic [15:0] if_id_out, if_id_pc_out;
  logic if_id_valid_out;
  int n_cmp = 0;
  int n_bad = 0;

  if_id_register dut (
    .clock(clock), .reset(reset),
    .if_id_inst_in(if_id_inst_in), .if_id_pc_in(if_id_pc_in), .if_id_valid_in(if_id_valid_in),
    .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .if_id_out(if_id_out), .if_id_pc_out(if_id_pc_out), .if_id_valid_out(if_id_valid_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic rst, flush, stall;
    logic [15:0] inst, pc;
    logic valid;
    logic [15:0] e_inst, e_pc;
    logic e_valid;
  } vec_t;

  vec_t v[21];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [15:0] ei, input logic [15:0] ep, input logic ev);
    check({name, ".inst"}, if_id_out, ei);
    check({name, ".pc"}, if_id_pc_out, ep);
    check({name, ".valid"}, {15'd0, if_id_valid_out}, {15'd0, ev});
  endtask

  task automatic drive(input logic r, input logic f, input logic s, input logic [15:0] i,
                       input logic [15:0] p, input logic vl);
    reset = r; if_id_flush = f; if_id_stall = s;
    if_id_inst_in = i; if_id_pc_in = p; if_id_valid_in = vl;
  endtask

  initial begin
    logic [15:0] pi, pp;
    logic pv;
    //        rst flush stall inst      pc        vld  exp inst  exp pc    exp vld
    v[0]  = '{1'b1, 1'b0, 1'b0, 16'h7777, 16'h0002, 1'b1, 16'h0000, 16'h0000, 1'b0};
    v[1]  = '{1'b0, 1'b0, 1'b0, 16'hAAAA, 16'h0004, 1'b1, 16'hAAAA, 16'h0004, 1'b1};
    v[2]  = '{1'b0, 1'b0, 1'b0, 16'hAAAA, 16'h0004, 1'b1, 16'hAAAA, 16'h0004, 1'b1};
    v[3]  = '{1'b0, 1'b0, 1'b0, 16'hAAAA, 16'h0004, 1'b1, 16'hAAAA, 16'h0004, 1'b1};
    v[4]  = '{1'b0, 1'b0, 1'b0, 16'hAAAA, 16'h0004, 1'b1, 16'hAAAA, 16'h0004, 1'b1};
    v[5]  = '{1'b0, 1'b0, 1'b0, 16'h0001, 16'h0006, 1'b1, 16'h0001, 16'h0006, 1'b1};
    v[6]  = '{1'b0, 1'b0, 1'b0, 16'h1234, 16'h0008, 1'b1, 16'h1234, 16'h0008, 1'b1};
    v[7]  = '{1'b0, 1'b0, 1'b1, 16'h5678, 16'h000A, 1'b1, 16'h1234, 16'h0008, 1'b1};
    v[8]  = '{1'b0, 1'b0, 1'b1, 16'h5678, 16'h000A, 1'b1, 16'h1234, 16'h0008, 1'b1};
    v[9]  = '{1'b0, 1'b0, 1'b1, 16'h5678, 16'h000A, 1'b1, 16'h1234, 16'h0008, 1'b1};
    v[10] = '{1'b0, 1'b0, 1'b0, 16'h5678, 16'h000A, 1'b1, 16'h5678, 16'h000A, 1'b1};
    v[11] = '{1'b0, 1'b1, 1'b1, 16'h9999, 16'h000C, 1'b1, 16'h0000, 16'h0000, 1'b0};
    v[12] = '{1'b0, 1'b0, 1'b0, 16'h9999, 16'h000C, 1'b1, 16'h9999, 16'h000C, 1'b1};
    v[13] = '{1'b0, 1'b0, 1'b0, 16'hBEEF, 16'h000E, 1'b1, 16'hBEEF, 16'h000E, 1'b1};
    v[14] = '{1'b1, 1'b0, 1'b0, 16'h1111, 16'h0010, 1'b1, 16'h0000, 16'h0000, 1'b0};
    v[15] = '{1'b0, 1'b0, 1'b0, 16'h1111, 16'h0010, 1'b1, 16'h1111, 16'h0010, 1'b1};
    v[16] = '{1'b0, 1'b0, 1'b0, 16'h2222, 16'h0012, 1'b0, 16'h2222, 16'h0012, 1'b0};
    v[17] = '{1'b1, 1'b0, 1'b1, 16'h3333, 16'h0014, 1'b1, 16'h0000, 16'h0000, 1'b0};
    v[18] = '{1'b0, 1'b1, 1'b0, 16'h4444, 16'h0016, 1'b1, 16'h0000, 16'h0000, 1'b0};
    v[19] = '{1'b0, 1'b0, 1'b1, 16'h5555, 16'h0018, 1'b1, 16'h0000, 16'h0000, 1'b0};
    v[20] = '{1'b0, 1'b0, 1'b0, 16'h5555, 16'h0018, 1'b1, 16'h5555, 16'h0018, 1'b1};

    // Power-up without reset: defined bubble state before any edge, then after two idle edges.
    #1 check_all("powerup", 16'h0000, 16'h0000, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    repeat (2) @(posedge clock);
    #1 check_all("powerup2", 16'h0000, 16'h0000, 1'b0);

    pi = 16'h0000; pp = 16'h0000; pv = 1'b0;
    for (int k = 0; k < 21; k++) begin
      @(negedge clock);
      drive(v[k].rst, v[k].flush, v[k].stall, v[k].inst, v[k].pc, v[k].valid);
      #1 check_all($sformatf("pre[%0d]", k), pi, pp, pv);
      @(posedge clock);
      #1 check_all($sformatf("vec[%0d]", k), v[k].e_inst, v[k].e_pc, v[k].e_valid);
      pi = v[k].e_inst; pp = v[k].e_pc; pv = v[k].e_valid;
    end

    // Input glitches between edges: only the value at the rising edge is captured.
    @(negedge clock);
    drive(1'b0, 1'b0, 1'b0, 16'hABCD, 16'h0020, 1'b1);
    #2 drive(1'b0, 1'b0, 1'b0, 16'hDCBA, 16'h0022, 1'b0);
    #1 check_all("glitch_pre", 16'h5555, 16'h0018, 1'b1);
    @(posedge clock);
    #1 check_all("glitch_post", 16'hDCBA, 16'h0022, 1'b0);

    // Long stall with changing inputs, then resume on the first unstalled edge.
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      drive(1'b0, 1'b0, 1'b1, 16'h6000 + 16'(k), 16'h0030 + 16'(k), 1'b1);
      @(posedge clock);
      #1 check_all($sformatf("stall[%0d]", k), 16'hDCBA, 16'h0022, 1'b0);
    end
    @(negedge clock);
    drive(1'b0, 1'b0, 1'b0, 16'hC0DE, 16'h0040, 1'b1);
    @(posedge clock);
    #1 check_all("resume", 16'hC0DE, 16'h0040, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
